// File: rtl/call_stack_if.sv
// Bundle of the call/return stack control and status signals between the
// control path (master) and the call_stack (slave).
interface call_stack_if #(
    parameter int PC_SIZE = 5,
    parameter int DEPTH   = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic               cal;
    logic               ret;
    logic               clr;
    logic [PC_SIZE-1:0] instr_addr;
    logic [PC_SIZE-1:0] ret_addr;
    logic [CNT_W-1:0]   depth;
    logic               empty;
    logic               full;
    logic               overflow;
    logic               underflow;

    modport master (
        output cal, ret, clr, instr_addr,
        input  ret_addr, depth, empty, full, overflow, underflow
    );

    modport slave (
        input  cal, ret, clr, instr_addr,
        output ret_addr, depth, empty, full, overflow, underflow
    );
endinterface

// File: rtl/call_stack.sv
// Hardware return-address stack: circular buffer with a top pointer, depth
// counter and sticky overflow/underflow flags. Define CALL_STACK_WRAP_EN to
// let a push while full overwrite the oldest entry instead of being dropped.
module call_stack #(
    parameter int PC_SIZE = 5,
    parameter int DEPTH   = 4
) (
    input  logic          clk,
    input  logic          rst,
    call_stack_if.slave   stk
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PC_SIZE-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   top_q, top_d;
    logic [CNT_W-1:0]   depth_q, depth_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic               mem_we;
    logic [PTR_W-1:0]   mem_wa;
    logic [PC_SIZE-1:0] push_val;
    logic               is_empty;
    logic               is_full;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) return '0;
        return p + 1'b1;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
        if (p == '0) return PTR_W'(DEPTH - 1);
        return p - 1'b1;
    endfunction

    assign push_val = stk.instr_addr + 1'b1;
    assign is_empty = (depth_q == '0);
    assign is_full  = (depth_q == CNT_W'(DEPTH));

    always_comb begin
        top_d   = top_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        mem_we  = 1'b0;
        mem_wa  = ptr_inc(top_q);
        if (stk.clr) begin
            depth_d = '0;
        end else if (!rst) begin
            unique case ({stk.cal, stk.ret})
                2'b10: begin
                    if (!is_full) begin
                        mem_we  = 1'b1;
                        top_d   = ptr_inc(top_q);
                        depth_d = depth_q + 1'b1;
                    end else begin
                        ovf_d = 1'b1;
`ifdef CALL_STACK_WRAP_EN
                        // Oldest entry sits just past the top when full.
                        mem_we = 1'b1;
                        top_d  = ptr_inc(top_q);
`endif
                    end
                end
                2'b01: begin
                    if (!is_empty) begin
                        top_d   = ptr_dec(top_q);
                        depth_d = depth_q - 1'b1;
                    end else begin
                        unf_d = 1'b1;
                    end
                end
                2'b11: begin
                    mem_we = 1'b1;
                    if (!is_empty) begin
                        mem_wa = top_q;
                    end else begin
                        top_d   = ptr_inc(top_q);
                        depth_d = CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            top_q   <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            top_q   <= top_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_wa] <= push_val;
        end
    end

    assign stk.ret_addr  = is_empty ? '0 : mem_q[top_q];
    assign stk.depth     = depth_q;
    assign stk.empty     = is_empty;
    assign stk.full      = is_full;
    assign stk.overflow  = ovf_q;
    assign stk.underflow = unf_q;
endmodule

// File: tb/tb_call_stack.sv
// Directed bench for call_stack (DEPTH=4, PC_SIZE=5): a vector table plus
// hand-written multi-cycle sequences; follows CALL_STACK_WRAP_EN if defined.
module tb_call_stack;
    localparam int PC_SIZE = 5;
    localparam int DEPTH   = 4;
`ifdef CALL_STACK_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    typedef struct {
        logic       rst, cal, ret, clr;
        logic [4:0] addr;
        logic [2:0] d;
        logic       e, f, o, u;
        logic [4:0] ra;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    vec_t vq[$];
    int   n_vec = 0;
    int   n_err = 0;

    call_stack_if #(.PC_SIZE(PC_SIZE), .DEPTH(DEPTH)) bus ();

    call_stack #(.PC_SIZE(PC_SIZE), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .stk (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic void add(input logic r, c, t, cl, input logic [4:0] a,
                                input logic [2:0] d, input logic e, f, o, u,
                                input logic [4:0] ra);
        vec_t v;
        v.rst = r; v.cal = c; v.ret = t; v.clr = cl; v.addr = a;
        v.d = d; v.e = e; v.f = f; v.o = o; v.u = u; v.ra = ra;
        vq.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [2:0] d, input logic e, f, o, u,
                       input logic [4:0] ra);
        logic [12:0] act, exp;
        act = {bus.depth, bus.empty, bus.full, bus.overflow, bus.underflow, bus.ret_addr};
        exp = {d, e, f, o, u, ra};
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got depth=%0d empty=%b full=%b ovf=%b unf=%b ret_addr=%0d, want depth=%0d empty=%b full=%b ovf=%b unf=%b ret_addr=%0d",
                     nm, bus.depth, bus.empty, bus.full, bus.overflow, bus.underflow,
                     bus.ret_addr, d, e, f, o, u, ra);
        end
    endtask

    task automatic drive(input logic r, c, t, cl, input logic [4:0] a);
        rst = r; bus.cal = c; bus.ret = t; bus.clr = cl; bus.instr_addr = a;
    endtask

    task automatic step(input logic r, c, t, cl, input logic [4:0] a);
        drive(r, c, t, cl, a);
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);

        //    rst cal ret clr addr   d  e  f  o  u  ra
        add(1, 0, 0, 0, 5'd0,  3'd0, 1, 0, 0, 0, 5'd0);   // reset
        add(0, 1, 0, 0, 5'd2,  3'd1, 0, 0, 0, 0, 5'd3);   // nesting
        add(0, 1, 0, 0, 5'd5,  3'd2, 0, 0, 0, 0, 5'd6);
        add(0, 1, 0, 0, 5'd9,  3'd3, 0, 0, 0, 0, 5'd10);
        add(0, 0, 1, 0, 5'd0,  3'd2, 0, 0, 0, 0, 5'd6);
        add(0, 0, 1, 0, 5'd0,  3'd1, 0, 0, 0, 0, 5'd3);
        add(0, 0, 1, 0, 5'd0,  3'd0, 1, 0, 0, 0, 5'd0);
        add(0, 0, 1, 0, 5'd0,  3'd0, 1, 0, 0, 1, 5'd0);   // underflow
        add(0, 1, 0, 0, 5'd31, 3'd1, 0, 0, 0, 1, 5'd0);   // address wrap
        add(0, 0, 1, 0, 5'd0,  3'd0, 1, 0, 0, 1, 5'd0);
        add(0, 1, 0, 0, 5'd2,  3'd1, 0, 0, 0, 1, 5'd3);   // simultaneous
        add(0, 1, 1, 0, 5'd7,  3'd1, 0, 0, 0, 1, 5'd8);
        add(0, 0, 1, 0, 5'd0,  3'd0, 1, 0, 0, 1, 5'd0);
        add(0, 1, 1, 0, 5'd4,  3'd1, 0, 0, 0, 1, 5'd5);
        add(0, 0, 0, 0, 5'd9,  3'd1, 0, 0, 0, 1, 5'd5);   // hold
        add(0, 0, 0, 1, 5'd0,  3'd0, 1, 0, 0, 1, 5'd0);   // flush keeps flags
        add(1, 0, 0, 0, 5'd0,  3'd0, 1, 0, 0, 0, 5'd0);
        add(0, 1, 0, 0, 5'd0,  3'd1, 0, 0, 0, 0, 5'd1);   // overflow
        add(0, 1, 0, 0, 5'd1,  3'd2, 0, 0, 0, 0, 5'd2);
        add(0, 1, 0, 0, 5'd2,  3'd3, 0, 0, 0, 0, 5'd3);
        add(0, 1, 0, 0, 5'd3,  3'd4, 0, 1, 0, 0, 5'd4);
        add(0, 1, 0, 0, 5'd4,  3'd4, 0, 1, 1, 0, WRAP ? 5'd5 : 5'd4);
        add(0, 0, 1, 0, 5'd0,  3'd3, 0, 0, 1, 0, WRAP ? 5'd4 : 5'd3);
        add(0, 0, 1, 0, 5'd0,  3'd2, 0, 0, 1, 0, WRAP ? 5'd3 : 5'd2);
        add(0, 0, 1, 0, 5'd0,  3'd1, 0, 0, 1, 0, WRAP ? 5'd2 : 5'd1);
        add(0, 0, 1, 0, 5'd0,  3'd0, 1, 0, 1, 0, 5'd0);

        @(negedge clk);
        foreach (vq[i]) begin
            step(vq[i].rst, vq[i].cal, vq[i].ret, vq[i].clr, vq[i].addr);
            chk($sformatf("vec%0d", i), vq[i].d, vq[i].e, vq[i].f, vq[i].o, vq[i].u, vq[i].ra);
        end

        // Flush with a simultaneous call after overflow, then reset with a ret.
        step(1, 0, 0, 0, 5'd0);
        for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 5'(10 + k));
        chk("three_push", 3'd3, 0, 0, 0, 0, 5'd13);
        step(0, 1, 0, 0, 5'd13);
        step(0, 1, 0, 0, 5'd14);
        chk("fifth_push", 3'd4, 0, 1, 1, 0, WRAP ? 5'd15 : 5'd14);
        step(0, 1, 0, 1, 5'd20);
        chk("clr_with_cal", 3'd0, 1, 0, 1, 0, 5'd0);
        step(1, 0, 1, 0, 5'd0);
        chk("rst_with_ret", 3'd0, 1, 0, 0, 0, 5'd0);

        // ret_addr must present the top in the same cycle ret is raised.
        step(0, 1, 0, 0, 5'd6);
        step(0, 1, 0, 0, 5'd8);
        drive(0, 0, 1, 0, 5'd0);
        #1;
        chk("ret_same_cycle", 3'd2, 0, 0, 0, 0, 5'd9);
        @(posedge clk);
        #1;
        chk("ret_after_pop", 3'd1, 0, 0, 0, 0, 5'd7);

        drive(0, 0, 0, 0, 5'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
